// File: rtl/conf_int_mul_pkg.sv
// Shared types and helpers for the configurable-precision pipelined multiplier.
package conf_int_mul_pkg;

    // Operand width the stage record is laid out for; the top-level default follows it.
    localparam int CIM_DPW  = 32;
    localparam int CIM_ACCW = 2 * CIM_DPW;

    // One pipeline slot: the op travels with its mode, its multiplicand, the
    // multiplier bits not yet consumed (low slice first) and the running sum.
    typedef struct packed {
        logic                valid;
        logic                acc_mode;
        logic [CIM_DPW-1:0]  a;
        logic [CIM_DPW-1:0]  b_remaining;
        logic [CIM_ACCW-1:0] acc;
    } mul_stage_t;

    // Width of the multiplier slice consumed by each stage.
    function automatic int cim_slice_width(input int dpw, input int stages);
        return dpw / stages;
    endfunction

    // Approximate-mode mask: keep the top op_bits of a dpw-bit operand, clear the rest.
    function automatic logic [CIM_DPW-1:0] apx_mask(input int dpw, input int op_bits);
        logic [CIM_DPW-1:0] m;
        m = {CIM_DPW{1'b0}};
        for (int i = 0; i < CIM_DPW; i++) begin
            if ((i >= dpw - op_bits) && (i < dpw)) begin
                m[i] = 1'b1;
            end else begin
                m[i] = 1'b0;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/conf_int_mul_pipe_pp_stage.sv
// One partial-product step: acc_out = acc_in + sext(a) * slice << SHIFT.
// The top slice carries the multiplier sign; lower slices are plain magnitudes.
module conf_int_mul_pp_stage #(
    parameter int DW           = 32,
    parameter int SW           = 8,
    parameter int SHIFT        = 0,
    parameter bit IS_TOP_SLICE = 1'b0
) (
    input  logic [DW-1:0]   a,
    input  logic [SW-1:0]   b_slice,
    input  logic [2*DW-1:0] acc_in,
    output logic [2*DW-1:0] acc_out
);

    logic [2*DW-1:0] a_ext_s;
    logic [2*DW-1:0] slice_ext_s;
    logic [2*DW-1:0] pp_s;

    // Extend both factors to accumulator width; modular product is exact in 2*DW bits.
    always_comb begin
        a_ext_s = {{DW{a[DW-1]}}, a};
        if (IS_TOP_SLICE) begin
            slice_ext_s = {{(2*DW-SW){b_slice[SW-1]}}, b_slice};
        end else begin
            slice_ext_s = {{(2*DW-SW){1'b0}}, b_slice};
        end
        pp_s    = a_ext_s * slice_ext_s;
        acc_out = acc_in + (pp_s << SHIFT);
    end

endmodule

// File: rtl/conf_int_mul_pipe.sv
// Pipelined signed multiplier with per-op accurate/approximate precision and
// valid/ready handshakes. One multiplier slice is folded in per stage; a single
// global enable stalls the whole pipe when the output slot is full and not taken.
module conf_int_mul_pipe
    import conf_int_mul_pkg::*;
#(
    parameter int DATA_PATH_BITWIDTH = CIM_DPW,
    parameter int OP_BITWIDTH        = 28,
    parameter int NUM_STAGES         = 4
) (
    input  logic                            clk,
    input  logic                            racc,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            acc_mode,
    input  logic [DATA_PATH_BITWIDTH-1:0]   a,
    input  logic [DATA_PATH_BITWIDTH-1:0]   b,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [2*DATA_PATH_BITWIDTH-1:0] d,
    output logic                            busy
);

    localparam int              DW   = DATA_PATH_BITWIDTH;
    localparam int              SW   = cim_slice_width(DW, NUM_STAGES);
    localparam logic [DW-1:0]   MASK = apx_mask(DW, OP_BITWIDTH);

    mul_stage_t                     stage_in_s [NUM_STAGES];
    mul_stage_t                     stage_d    [NUM_STAGES];
    mul_stage_t                     stage_q    [NUM_STAGES];
    logic [NUM_STAGES-1:0][2*DW-1:0] acc_out_s;
    logic                           en_s;

    // Pipe advances whenever the last slot is empty or being drained.
    always_comb begin
        en_s     = !stage_q[NUM_STAGES-1].valid || out_ready;
        in_ready = en_s;
    end

    // Stage inputs: conditioned operands into stage 0, previous slot elsewhere.
    always_comb begin
        stage_in_s[0]          = '0;
        stage_in_s[0].valid    = in_valid;
        stage_in_s[0].acc_mode = acc_mode;
        if (acc_mode) begin
            stage_in_s[0].a           = a;
            stage_in_s[0].b_remaining = b;
        end else begin
            stage_in_s[0].a           = a & MASK;
            stage_in_s[0].b_remaining = b & MASK;
        end
        for (int s = 1; s < NUM_STAGES; s++) begin
            stage_in_s[s] = stage_q[s-1];
        end
    end

    for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
        conf_int_mul_pp_stage #(
            .DW          (DW),
            .SW          (SW),
            .SHIFT       (g * SW),
            .IS_TOP_SLICE(g == NUM_STAGES - 1)
        ) u_pp (
            .a      (stage_in_s[g].a),
            .b_slice(stage_in_s[g].b_remaining[SW-1:0]),
            .acc_in (stage_in_s[g].acc),
            .acc_out(acc_out_s[g])
        );
    end

    // Next slot contents: advance with the new partial sum, or hold on stall.
    always_comb begin
        for (int s = 0; s < NUM_STAGES; s++) begin
            if (en_s) begin
                stage_d[s].valid       = stage_in_s[s].valid;
                stage_d[s].acc_mode    = stage_in_s[s].acc_mode;
                stage_d[s].a           = stage_in_s[s].a;
                stage_d[s].b_remaining = stage_in_s[s].b_remaining >> SW;
                stage_d[s].acc         = acc_out_s[s];
            end else begin
                stage_d[s] = stage_q[s];
            end
        end
    end

    // Slot registers; reset empties the pipe and clears all data.
    always_ff @(posedge clk) begin
        if (!racc) begin
            for (int s = 0; s < NUM_STAGES; s++) begin
                stage_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < NUM_STAGES; s++) begin
                stage_q[s] <= stage_d[s];
            end
        end
    end

    // Result comes straight from the last slot; busy is any slot occupied.
    always_comb begin
        out_valid = stage_q[NUM_STAGES-1].valid;
        d         = stage_q[NUM_STAGES-1].acc;
        busy      = 1'b0;
        for (int s = 0; s < NUM_STAGES; s++) begin
            busy = busy | stage_q[s].valid;
        end
    end

endmodule

// File: tb/tb_conf_int_mul_pipe.sv
// Bench for conf_int_mul_pipe: directed table, back-pressure, mid-flight reset
// and a randomized run against an arithmetic reference with an in-order queue.
module tb_conf_int_mul_pipe;

    localparam int W   = 32;
    localparam int OPW = 28;
    localparam int NS  = 4;

    logic           clk = 1'b0;
    logic           racc;
    logic           in_valid;
    logic           in_ready;
    logic           acc_mode;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] d;
    logic           busy;

    always #5 clk = ~clk;

    conf_int_mul_pipe #(
        .DATA_PATH_BITWIDTH(W),
        .OP_BITWIDTH       (OPW),
        .NUM_STAGES        (NS)
    ) dut (
        .clk      (clk),
        .racc     (racc),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .acc_mode (acc_mode),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .d        (d),
        .busy     (busy)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int          n_acc = 0;
    int          n_xfer = 0;
    logic        last_acc = 1'b0;
    logic [63:0] exp_q[$];

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         mode;
        logic [63:0]  exp_d;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    // Reference: drop low bits in approximate mode, then an ordinary signed product.
    function automatic logic [63:0] ref_prod(input logic [W-1:0] x, input logic [W-1:0] y, input logic m);
        longint sx;
        longint sy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (!m) begin
            sx = (sx >>> (W - OPW)) <<< (W - OPW);
            sy = (sy >>> (W - OPW)) <<< (W - OPW);
        end
        return 64'(sx * sy);
    endfunction

    // One clock: observe the handshakes of this cycle, score them, then advance.
    task automatic step();
        logic xf;
        logic ac;
        #1;
        xf = racc && out_valid && out_ready;
        ac = racc && in_valid && in_ready;
        last_acc = ac;
        if (!racc) begin
            exp_q.delete();
        end else begin
            if (xf) begin
                n_xfer++;
                chk("result_expected", {63'd0, exp_q.size() != 0}, 64'd1);
                if (exp_q.size() != 0) begin
                    chk("scoreboard_d", d, exp_q.pop_front());
                end
            end
            if (ac) begin
                n_acc++;
                exp_q.push_back(ref_prod(a, b, acc_mode));
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Single op with no back-pressure: latency and value against a fixed expectation.
    task automatic run_single(input string name, input logic [W-1:0] xa, input logic [W-1:0] xb,
                              input logic m, input logic [63:0] exp_d);
        int lat;
        out_ready = 1'b1;
        a = xa; b = xb; acc_mode = m; in_valid = 1'b1;
        step();
        chk({name, "_accepted"}, {63'd0, last_acc}, 64'd1);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        chk({name, "_latency"}, 64'(lat), 64'(NS));
        chk({name, "_d"}, d, exp_d);
        step();
    endtask

    vec_t tbl[7];

    initial begin
        int idx;
        int x0;
        int acc_cnt;
        logic pend;
        logic [W-1:0] pick[5];

        tbl[0] = '{32'd3,          32'hFFFFFFFB, 1'b1, 64'hFFFFFFFFFFFFFFF1};
        tbl[1] = '{32'd19,         32'd33,       1'b0, 64'd512};
        tbl[2] = '{32'd19,         32'd33,       1'b1, 64'd627};
        tbl[3] = '{32'hFFFFFFFF,   32'hFFFFFFFF, 1'b0, 64'd256};
        tbl[4] = '{32'h80000000,   32'h80000000, 1'b1, 64'h4000000000000000};
        tbl[5] = '{32'h7FFFFFFF,   32'h80000000, 1'b1, 64'hC000000080000000};
        tbl[6] = '{32'hFFFFFFFF,   32'd1,        1'b1, 64'hFFFFFFFFFFFFFFFF};

        racc = 1'b0; in_valid = 1'b0; out_ready = 1'b1; acc_mode = 1'b1;
        a = 32'd0; b = 32'd0;
        step();
        in_valid = 1'b1; a = 32'd7; b = 32'd7;
        step();
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_d", d, 64'd0);
        in_valid = 1'b0;
        racc = 1'b1;
        step();
        chk("reset_no_accept", {63'd0, out_valid}, 64'd0);

        // Directed table
        for (int i = 0; i < 7; i++) begin
            run_single($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].mode, tbl[i].exp_d);
        end

        // Back-pressure from empty: capacity, stall, hold, then in-order drain
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 10; c++) begin
            in_valid = (idx < 6); a = 32'(idx + 1); b = 32'(-(idx + 3)); acc_mode = 1'b1;
            step();
            if (last_acc) idx++;
            if (out_valid) chk("bp_hold_d", d, 64'hFFFFFFFFFFFFFFFD);
        end
        chk("bp_capacity", 64'(idx), 64'd4);
        chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
        chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
        out_ready = 1'b1;
        x0 = n_xfer;
        for (int c = 0; c < 6; c++) begin
            in_valid = (idx < 6); a = 32'(idx + 1); b = 32'(-(idx + 3)); acc_mode = 1'b1;
            step();
            if (last_acc) idx++;
        end
        in_valid = 1'b0;
        chk("bp_all_accepted", 64'(idx), 64'd6);
        chk("bp_drain_rate", 64'(n_xfer - x0), 64'd6);
        chk("bp_queue_empty", 64'(exp_q.size()), 64'd0);

        // Reset with three ops in flight
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; a = 32'(i + 100); b = 32'(i + 5); acc_mode = 1'b1;
            step();
        end
        in_valid = 1'b0;
        racc = 1'b0;
        step();
        racc = 1'b1;
        chk("midreset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midreset_busy", {63'd0, busy}, 64'd0);
        chk("midreset_d", d, 64'd0);
        run_single("post_reset", 32'hFFFFFFF9, 32'd9, 1'b1, 64'hFFFFFFFFFFFFFFC1);

        // Randomized regression with random valid/ready and held pending ops
        pick[0] = 32'h80000000; pick[1] = 32'h7FFFFFFF; pick[2] = 32'hFFFFFFFF; pick[3] = 32'd0;
        acc_cnt = 0;
        pend = 1'b0;
        x0 = n_xfer;
        for (int c = 0; c < 5000 && acc_cnt < 500; c++) begin
            if (!pend && ($urandom_range(0, 9) < 7)) begin
                pend = 1'b1;
                pick[4] = $urandom;
                a = pick[$urandom_range(0, 4)];
                pick[4] = $urandom;
                b = pick[$urandom_range(0, 4)];
                if ($urandom_range(0, 3) == 0) a = $urandom;
                if ($urandom_range(0, 3) == 0) b = $urandom;
                acc_mode = 1'($urandom_range(0, 1));
            end
            in_valid = pend;
            out_ready = ($urandom_range(0, 9) < 7);
            step();
            if (last_acc) begin
                pend = 1'b0;
                acc_cnt++;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 50 && (exp_q.size() != 0 || busy); c++) begin
            step();
        end
        chk("rand_accepted", 64'(acc_cnt), 64'd500);
        chk("rand_delivered", 64'(n_xfer - x0), 64'd500);
        chk("rand_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("rand_idle", {63'd0, busy}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
